// File: rtl/lsu.sv
// Load/store unit: one request/grant/response bus transaction per accepted access.
// Misaligned or illegal accesses complete with an error and never touch the bus.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic [2:0]  func3,
  input  logic [7:0]  wmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_wen;
  logic [2:0]    r_func3;
  logic [1:0]    r_addr_lo;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [3:0]    r_bus_wstrb;
  logic          r_err;
  logic          w_err_nxt;
  logic [31:0]   r_rdata;
  logic [31:0]   w_rdata_nxt;
  logic          w_timeout;
  logic          w_accept;
  logic          w_unused;

  // Upper mask bits carry no information for a 32-bit bus.
  assign w_unused = ^wmask[7:4];

  function automatic logic f_illegal(input logic wen, input logic [2:0] f3, input logic [1:0] a);
    logic bad_op;
    logic mis;
    if (wen) begin
      bad_op = (f3 > 3'd2);
    end else begin
      bad_op = (f3 == 3'd3) || (f3 > 3'd5);
    end
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return bad_op | mis;
  endfunction

  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = w >> {a, 3'b000};
    case (f3)
      3'd0:    ext = {{24{sh[7]}}, sh[7:0]};
      3'd4:    ext = {24'd0, sh[7:0]};
      3'd1:    ext = {{16{sh[15]}}, sh[15:0]};
      3'd5:    ext = {16'd0, sh[15:0]};
      3'd2:    ext = sh;
      default: ext = 32'd0;
    endcase
    return ext;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, completion status and load result selection.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_err_nxt   = f_illegal(mem_wen, func3, addr[1:0]);
          w_rdata_nxt = 32'd0;
          w_state_nxt = w_err_nxt ? S_DONE : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bus_gnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (bus_rvalid) begin
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_wen ? 32'd0 : f_extend(r_func3, r_addr_lo, bus_rdata);
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timeout counter, restarted every time the FSM sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (((r_state == S_REQ) || (r_state == S_WAIT)) && (TIMEOUT != 0)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Request fields and pre-aligned bus fields captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen       <= 1'b0;
      r_func3     <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_wstrb <= 4'd0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      if (w_accept) begin
        r_wen       <= mem_wen;
        r_func3     <= func3;
        r_addr_lo   <= addr[1:0];
        r_bus_addr  <= {addr[31:2], 2'b00};
        r_bus_wdata <= wdata << {addr[1:0], 3'b000};
        r_bus_wstrb <= mem_wen ? (wmask[3:0] << addr[1:0]) : 4'd0;
      end
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_err   = (r_state == S_DONE) && r_err;
  assign rdata      = (r_state == S_DONE) ? r_rdata : 32'd0;
  assign bus_req    = (r_state == S_REQ);
  assign bus_we     = r_wen;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;

endmodule
